// File: rtl/regfile_arb_pkg.sv
// Shared types and sizing for the register-file write-port arbiter.
package regfile_arb_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int IDX_W    = 3;
   localparam int DR_W     = 4;

   // Last register index visited by the clear sweep.
   localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(NUM_REGS - 1);

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

   // The register file DR input is wider than a requester index; upper bits are always zero.
   function automatic logic [DR_W-1:0] make_dr(input logic [IDX_W-1:0] idx);
      return {{(DR_W-IDX_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational from the current
// requests and a 1-bit pointer; the pointer only moves when the parent
// actually accepts the granted request, and then points at the loser.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic gnt0,
   output logic gnt1
);

   // 0: requester 0 wins a tie, 1: requester 1 wins a tie
   logic ptr_q;
   logic ptr_d;

   // Grant selection and pointer update on accepted grants.
   always_comb begin
      gnt0  = req0 && (!req1 || !ptr_q);
      gnt1  = req1 && (!req0 ||  ptr_q);
      ptr_d = ptr_q;
      if (accept && gnt0) begin
         ptr_d = 1'b1;
      end else if (accept && gnt1) begin
         ptr_d = 1'b0;
      end
   end

   // Pointer register; reset favours requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port. Shares it between the CPU writeback
// path and the debug loader with round-robin arbitration, and runs a clear
// sweep that writes zero to every register. All outputs are registered:
// an acceptance at one edge shows up as LD_REG/gnt/DR/wr_data in the
// following cycle, and the register file captures on the edge after that.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              clr_req,
   output logic              clr_busy,
   input  logic              cpu_req,
   input  logic [IDX_W-1:0]  cpu_idx,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_gnt,
   input  logic              dbg_req,
   input  logic [IDX_W-1:0]  dbg_idx,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_gnt,
   output logic [DR_W-1:0]   DR,
   output logic              LD_REG,
   output logic [DATA_W-1:0] wr_data
);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              ld_reg_q, ld_reg_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              clr_busy_q, clr_busy_d;
   logic [DR_W-1:0]   dr_q, dr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic arb_open;
   logic pick_cpu;
   logic pick_dbg;

   // Requests are only arbitrated in ARB when no clear is being started;
   // a clear request wins the edge and leaves both requests pending.
   assign arb_open = (state_q == ARB) && !clr_req;

   rr_arbiter2 u_rr (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .req0   (cpu_req),
      .req1   (dbg_req),
      .accept (arb_open),
      .gnt0   (pick_cpu),
      .gnt1   (pick_dbg)
   );

   // Next-state and next-output decode for the ARB/CLEAR sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ld_reg_d   = 1'b0;
      cpu_gnt_d  = 1'b0;
      dbg_gnt_d  = 1'b0;
      clr_busy_d = 1'b0;
      dr_d       = dr_q;
      wr_data_d  = wr_data_q;

      case (state_q)
         ARB: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (pick_cpu) begin
               ld_reg_d  = 1'b1;
               cpu_gnt_d = 1'b1;
               dr_d      = make_dr(cpu_idx);
               wr_data_d = cpu_data;
            end else if (pick_dbg) begin
               ld_reg_d  = 1'b1;
               dbg_gnt_d = 1'b1;
               dr_d      = make_dr(dbg_idx);
               wr_data_d = dbg_data;
            end
         end

         CLEAR: begin
            // One zero write per cycle; clr_req is not looked at here.
            ld_reg_d   = 1'b1;
            clr_busy_d = 1'b1;
            dr_d       = make_dr(cnt_q);
            wr_data_d  = '0;
            if (cnt_q == CLR_LAST) begin
               state_d = ARB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end

         default: begin
            state_d = ARB;
            cnt_d   = '0;
         end
      endcase
   end

   // State, sweep counter and registered outputs; reset abandons any sweep or grant.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ARB;
         cnt_q      <= '0;
         ld_reg_q   <= 1'b0;
         cpu_gnt_q  <= 1'b0;
         dbg_gnt_q  <= 1'b0;
         clr_busy_q <= 1'b0;
         dr_q       <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_reg_q   <= ld_reg_d;
         cpu_gnt_q  <= cpu_gnt_d;
         dbg_gnt_q  <= dbg_gnt_d;
         clr_busy_q <= clr_busy_d;
         dr_q       <= dr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign LD_REG   = ld_reg_q;
   assign cpu_gnt  = cpu_gnt_q;
   assign dbg_gnt  = dbg_gnt_q;
   assign clr_busy = clr_busy_q;
   assign DR       = dr_q;
   assign wr_data  = wr_data_q;

endmodule
